// File: rtl/pit_interval_timer.sv
// Programmable interval timer: a register-mapped down-counter that emits a TICK pulse
// and a level IRQ on terminal count, in periodic (auto-reload) or one-shot mode.
module pit_interval_timer #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        tick,
  output logic        irq
);

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_LOAD    = 2'd1;
  localparam logic [1:0] ADDR_COUNT   = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic             auto_reload_q, auto_reload_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             ctrl_wr, load_wr, status_wr;
  logic             terminal;
  logic [31:0]      rd_mux;

  always_comb begin
    ctrl_wr   = wr_en && (addr == ADDR_CONTROL);
    load_wr   = wr_en && (addr == ADDR_LOAD);
    status_wr = wr_en && (addr == ADDR_STATUS);
    // Terminal is judged on the pre-edge state, so a LOAD write landing here
    // still lets the event fire while COUNT takes the new value.
    terminal  = en_q && (count_q == '0);

    en_d          = en_q;
    irq_en_d      = irq_en_q;
    auto_reload_d = auto_reload_q;
    if (ctrl_wr) begin
      en_d          = wdata[0];
      irq_en_d      = wdata[1];
      auto_reload_d = wdata[2];
    end else if (terminal && !auto_reload_q) begin
      en_d = 1'b0;
    end

    load_d  = load_wr ? wdata[WIDTH-1:0] : load_q;

    count_d = count_q;
    if (load_wr) begin
      count_d = wdata[WIDTH-1:0];
    end else if (en_q) begin
      if (count_q != '0)      count_d = count_q - WIDTH'(1);
      else if (auto_reload_q) count_d = load_q;
      else                    count_d = '0;
    end

    // A terminal event outranks a same-cycle write-1-to-clear.
    pending_d = pending_q;
    if (terminal)                   pending_d = 1'b1;
    else if (status_wr && wdata[0]) pending_d = 1'b0;

    tick_d = terminal;

    rd_mux = 32'd0;
    case (addr)
      ADDR_CONTROL: rd_mux = {29'd0, auto_reload_q, irq_en_q, en_q};
      ADDR_LOAD:    rd_mux = 32'(load_q);
      ADDR_COUNT:   rd_mux = 32'(count_q);
      ADDR_STATUS:  rd_mux = {31'd0, pending_q};
      default:      rd_mux = 32'd0;
    endcase

    // Read handshake: rd_en in cycle N yields rvalid high for exactly cycle N+1
    // with rdata holding the pre-update register value; rdata then holds until
    // the next read. There is no backpressure.
    rvalid_d = rd_en;
    rdata_d  = rd_en ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q          <= 1'b0;
      irq_en_q      <= 1'b0;
      auto_reload_q <= 1'b0;
      load_q        <= '0;
      count_q       <= '0;
      pending_q     <= 1'b0;
      tick_q        <= 1'b0;
      rdata_q       <= 32'd0;
      rvalid_q      <= 1'b0;
    end else begin
      en_q          <= en_d;
      irq_en_q      <= irq_en_d;
      auto_reload_q <= auto_reload_d;
      load_q        <= load_d;
      count_q       <= count_d;
      pending_q     <= pending_d;
      tick_q        <= tick_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign tick   = tick_q;
  assign irq    = pending_q & irq_en_q;

endmodule

// File: tb/tb_pit_interval_timer.sv
// Directed bench for pit_interval_timer (WIDTH=16 to exercise truncation and
// zero-extension); expected values are hand-derived cycle by cycle.
module tb_pit_interval_timer;

  localparam int WIDTH = 16;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        tick;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  pit_interval_timer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .tick   (tick),
    .irq    (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // one clock edge, then settle 1ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    step();
    wr_en = 1'b0;
    wdata = 32'd0;
  endtask

  task automatic bus_read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    rd_en = 1'b1;
    addr  = a;
    step();
    rd_en = 1'b0;
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = 2'd0;
    wdata = 32'd0;
    step();
    step();
    chk("rst_rdata",  rdata, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_tick",   {31'd0, tick}, 32'd0);
    chk("rst_irq",    {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    step();
    bus_read_chk("rst_control", 2'd0, 32'd0);
    bus_read_chk("rst_load",    2'd1, 32'd0);
    bus_read_chk("rst_count",   2'd2, 32'd0);
    bus_read_chk("rst_status",  2'd3, 32'd0);
    step();
    chk("rvalid_drops", {31'd0, rvalid}, 32'd0);

    // periodic: LOAD=4, EN|AUTO_RELOAD -> tick every 5 cycles
    bus_write(2'd1, 32'd4);
    bus_write(2'd0, 32'h5);
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 5; i++) begin
        step();
        chk($sformatf("periodic_tick_p%0d_c%0d", p, i), {31'd0, tick}, {31'd0, i == 5});
      end
    end
    chk("periodic_irq_masked", {31'd0, irq}, 32'd0);
    bus_read_chk("periodic_status", 2'd3, 32'd1);
    bus_read_chk("periodic_control", 2'd0, 32'd5);
    bus_write(2'd0, 32'd0);
    bus_write(2'd3, 32'd1);
    bus_read_chk("status_cleared", 2'd3, 32'd0);

    // one-shot: LOAD=3, EN only -> exactly one tick, EN self-clears
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'h1);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("oneshot_tick_c%0d", i), {31'd0, tick}, {31'd0, i == 4});
    end
    bus_read_chk("oneshot_control", 2'd0, 32'd0);
    bus_read_chk("oneshot_count",   2'd2, 32'd0);
    bus_read_chk("oneshot_status",  2'd3, 32'd1);
    bus_write(2'd2, 32'd55);
    bus_read_chk("count_write_ignored", 2'd2, 32'd0);
    bus_write(2'd3, 32'd1);

    // IRQ: one-shot with IRQ_EN, then W1C clears next cycle
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h3);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("irq_c%0d", i), {31'd0, irq}, {31'd0, i == 3});
    end
    chk("irq_tick", {31'd0, tick}, 32'd1);
    bus_write(2'd3, 32'd1);
    chk("irq_w1c", {31'd0, irq}, 32'd0);

    // W1C landing on the terminal edge: set wins
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h7);
    step();
    step();
    bus_write(2'd3, 32'd1);
    chk("w1c_on_tick_tick", {31'd0, tick}, 32'd1);
    chk("w1c_on_tick_irq",  {31'd0, irq}, 32'd1);
    bus_write(2'd0, 32'd0);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    bus_read_chk("pending_retained", 2'd3, 32'd1);
    bus_write(2'd3, 32'd0);
    bus_read_chk("w0_no_effect", 2'd3, 32'd1);
    bus_write(2'd3, 32'd1);
    bus_read_chk("w1c_clears", 2'd3, 32'd0);

    // LOAD=0 auto-reload ticks every cycle; LOAD write at terminal still fires
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h5);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("load0_tick_c%0d", i), {31'd0, tick}, 32'd1);
    end
    bus_write(2'd1, 32'd9);
    chk("load_at_terminal_tick", {31'd0, tick}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("load9_tick_c%0d", i), {31'd0, tick}, {31'd0, i == 10});
    end
    bus_write(2'd0, 32'd0);
    bus_write(2'd3, 32'd1);

    // read COUNT while running; read latency and hold
    bus_write(2'd1, 32'd100);
    bus_write(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) step();
    bus_read_chk("running_count", 2'd2, 32'd95);
    step();
    chk("rvalid_one_cycle", {31'd0, rvalid}, 32'd0);
    chk("rdata_hold", rdata, 32'd95);

    // simultaneous write and read returns pre-write value
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr  = 2'd1;
    wdata = 32'd7;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("wr_rd_rvalid", {31'd0, rvalid}, 32'd1);
    chk("wr_rd_prewrite", rdata, 32'd100);
    bus_read_chk("wr_rd_postwrite", 2'd1, 32'd7);

    // WDATA bits above WIDTH are dropped, reads zero-extend
    bus_write(2'd0, 32'd0);
    bus_write(2'd1, 32'hABCD_1234);
    bus_read_chk("load_trunc",  2'd1, 32'h0000_1234);
    bus_read_chk("count_trunc", 2'd2, 32'h0000_1234);

    // asynchronous reset mid-run with tick and irq active
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h7);
    step();
    chk("pre_reset_tick", {31'd0, tick}, 32'd1);
    chk("pre_reset_irq",  {31'd0, irq}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdata", rdata, 32'd0);
    chk("async_rst_tick",  {31'd0, tick}, 32'd0);
    chk("async_rst_irq",   {31'd0, irq}, 32'd0);
    chk("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_irq",  {31'd0, irq}, 32'd0);
    chk("post_rst_tick", {31'd0, tick}, 32'd0);
    bus_read_chk("post_rst_count",   2'd2, 32'd0);
    bus_read_chk("post_rst_control", 2'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
